// File: rtl/fir_par_gen.sv
// L-lane unfolded FIR with writable coefficient bank and fixed 2-cycle latency.
// Define FIR_SAT_EN to clamp results to the W-bit range instead of wrapping.
module fir_par_gen #(
  parameter int unsigned W  = 8,
  parameter int unsigned NT = 11,
  parameter int unsigned L  = 3,
  parameter int unsigned AW = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [L*W-1:0] DIN,
  input  logic           VIN,
  input  logic           COEF_WE,
  input  logic [AW-1:0]  COEF_ADDR,
  input  logic [W-1:0]   COEF_DATA,
  output logic [L*W-1:0] DOUT,
  output logic           VOUT
);

  localparam int unsigned PW    = 2 * W;
  localparam int unsigned ACC_W = 2 * W + $clog2(NT);
  localparam int unsigned DL    = NT - 1 + L;

  logic signed [W-1:0]     coef  [NT];
  logic signed [W-1:0]     dline [DL];
  logic signed [PW-1:0]    prod  [L][NT];
  logic [1:0]              vpipe;
  logic signed [ACC_W-1:0] acc_c [L];
  logic [W-1:0]            res_c [L];
`ifdef FIR_SAT_EN
  logic signed [ACC_W-1:0] sh_c  [L];
`endif

  // coefficient bank; out-of-range addresses match no tap
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(NT); i++) coef[i] <= '0;
    end else if (COEF_WE) begin
      for (int i = 0; i < int'(NT); i++)
        if (COEF_ADDR == AW'(i)) coef[i] <= $signed(COEF_DATA);
    end
  end

  // delay line, index 0 newest; only advances on valid blocks
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int m = 0; m < int'(DL); m++) dline[m] <= '0;
    end else if (VIN) begin
      for (int m = int'(L); m < int'(DL); m++) dline[m] <= dline[m-int'(L)];
      for (int m = 0; m < int'(L); m++)
        dline[m] <= $signed(DIN[(int'(L)-1-m)*int'(W) +: W]);
    end
  end

  // product stage and valid pipe
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vpipe <= '0;
      for (int j = 0; j < int'(L); j++)
        for (int i = 0; i < int'(NT); i++) prod[j][i] <= '0;
    end else begin
      vpipe <= {vpipe[0], VIN};
      if (vpipe[0]) begin
        for (int j = 0; j < int'(L); j++)
          for (int i = 0; i < int'(NT); i++)
            prod[j][i] <= PW'(dline[int'(L)-1-j+i]) * PW'(coef[i]);
      end
    end
  end

  // lane sums, rescale by 2^-(W-1) with floor, then reduce to W bits
  always_comb begin
    for (int j = 0; j < int'(L); j++) begin
      acc_c[j] = '0;
      res_c[j] = '0;
`ifdef FIR_SAT_EN
      sh_c[j]  = '0;
`endif
    end
    for (int j = 0; j < int'(L); j++) begin
      for (int i = 0; i < int'(NT); i++)
        acc_c[j] = acc_c[j] + ACC_W'(prod[j][i]);
`ifdef FIR_SAT_EN
      sh_c[j] = acc_c[j] >>> (W - 1);
      if (!sh_c[j][ACC_W-1] && (|sh_c[j][ACC_W-2:W-1]))
        res_c[j] = {1'b0, {(W-1){1'b1}}};
      else if (sh_c[j][ACC_W-1] && !(&sh_c[j][ACC_W-2:W-1]))
        res_c[j] = {1'b1, {(W-1){1'b0}}};
      else
        res_c[j] = sh_c[j][W-1:0];
`else
      res_c[j] = W'(acc_c[j] >>> (W - 1));
`endif
    end
  end

  // output registers hold between valid results
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOUT <= '0;
      VOUT <= 1'b0;
    end else begin
      VOUT <= vpipe[1];
      if (vpipe[1]) begin
        for (int j = 0; j < int'(L); j++) DOUT[j*int'(W) +: W] <= res_c[j];
      end
    end
  end

endmodule

// File: tb/tb_fir_par_gen.sv
// Self-checking bench for fir_par_gen: arithmetic reference model with a
// per-cycle scoreboard, table-driven overflow vectors and directed corner cases.
module tb_fir_par_gen;
  localparam int unsigned W  = 8;
  localparam int unsigned NT = 11;
  localparam int unsigned L  = 3;
  localparam int unsigned AW = 4;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [L*W-1:0] DIN;
  logic           VIN;
  logic           COEF_WE;
  logic [AW-1:0]  COEF_ADDR;
  logic [W-1:0]   COEF_DATA;
  logic [L*W-1:0] DOUT;
  logic           VOUT;

  always #5 CLK = ~CLK;

  fir_par_gen #(.W(W), .NT(NT), .L(L), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .VIN(VIN), .COEF_WE(COEF_WE),
    .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA), .DOUT(DOUT), .VOUT(VOUT)
  );

  typedef struct {int due; logic [L*W-1:0] data;} pend_t;
  typedef struct {string name; logic [7:0] hv; logic [7:0] xv; logic [7:0] exp;} vec_t;

`ifdef FIR_SAT_EN
  localparam logic [7:0] E_POS = 8'h7F, E_NEG = 8'h80, E_NN = 8'h7F;
`else
  localparam logic [7:0] E_POS = 8'h6A, E_NEG = 8'h8B, E_NN = 8'h80;
`endif

  int             vectors = 0;
  int             miscompares = 0;
  int             cyc = 0;
  int             h[NT];
  int             hist[$];
  pend_t          pend[$];
  logic [L*W-1:0] last_dout;
  logic [L*W-1:0] outq[$];
  logic [L*W-1:0] gap_q[$];
  logic [L*W-1:0] d[4];
  int             gh[NT];
  vec_t           tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // y[n] = floor(sum h[i]*x[n-i] / 2^(W-1)), reduced to W bits
  function automatic logic [W-1:0] model_y(input int n);
    longint acc = 0;
    longint q;
    for (int i = 0; i < int'(NT); i++)
      if (n - i >= 0) acc += longint'(h[i]) * longint'(hist[n-i]);
    q = acc / 128;
    if (acc < 0 && (acc % 128) != 0) q -= 1;
`ifdef FIR_SAT_EN
    if (q > 127) q = 127;
    if (q < -128) q = -128;
`endif
    return W'(q);
  endfunction

  task automatic model_clear();
    hist.delete();
    pend.delete();
    for (int i = 0; i < int'(NT); i++) h[i] = 0;
    last_dout = '0;
  endtask

  // one clock: update model with the inputs captured at this edge, then check outputs
  task automatic step();
    pend_t          p;
    logic [L*W:0]   e;
    @(posedge CLK);
    #1;
    cyc++;
    if (COEF_WE && int'(COEF_ADDR) < int'(NT)) h[int'(COEF_ADDR)] = int'($signed(COEF_DATA));
    if (VIN) begin
      for (int j = 0; j < int'(L); j++) hist.push_back(int'($signed(DIN[j*int'(W) +: W])));
      p.due  = cyc + 2;
      p.data = '0;
      for (int j = 0; j < int'(L); j++)
        p.data[j*int'(W) +: W] = model_y(int'(hist.size()) - int'(L) + j);
      pend.push_back(p);
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = {1'b1, pend[0].data};
      last_dout = pend[0].data;
      void'(pend.pop_front());
    end else begin
      e = {1'b0, last_dout};
    end
    chk("cycle_out", {7'b0, VOUT, DOUT}, {7'b0, e});
    if (VOUT) outq.push_back(DOUT);
  endtask

  task automatic blk(input logic v, input logic [L*W-1:0] data);
    VIN = v;
    DIN = data;
    step();
  endtask

  task automatic wcoef(input int a, input int val);
    COEF_WE   = 1'b1;
    COEF_ADDR = AW'(a);
    COEF_DATA = W'(val);
    VIN       = 1'b0;
    step();
    COEF_WE   = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    RST = 1'b1;
    VIN = 1'b0;
    COEF_WE = 1'b0;
    #1;
    chk("rst_async", {7'b0, VOUT, DOUT}, 32'd0);
    model_clear();
    @(posedge CLK);
    #1;
    chk("rst_hold", {7'b0, VOUT, DOUT}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic run_impulse(input string tag);
    logic [31:0] act;
    outq.delete();
    blk(1'b1, 24'h000040);
    repeat (4) blk(1'b1, '0);
    VIN = 1'b0;
    repeat (3) step();
    chk({tag, "_count"}, outq.size(), 32'd5);
    for (int n = 0; n < 15; n++) begin
      act = (outq.size() > n / 3) ? 32'(outq[n/3][(n%3)*int'(W) +: W]) : 32'hFFFF_FFFF;
      chk({tag, "_y"}, act, (n < 11) ? 32'(n + 1) : 32'd0);
    end
  endtask

  initial begin
    tbl[0] = '{"ovf_pos",    8'h7F, 8'h7F, E_POS};
    tbl[1] = '{"ovf_neg",    8'h7F, 8'h80, E_NEG};
    tbl[2] = '{"ovf_negneg", 8'h80, 8'h80, E_NN};
    tbl[3] = '{"ovf_negpos", 8'h80, 8'h7F, E_NEG};
    tbl[4] = '{"in_range",   8'h10, 8'h40, 8'h58};

    DIN = '0; VIN = 1'b0; COEF_WE = 1'b0; COEF_ADDR = '0; COEF_DATA = '0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", {7'b0, VOUT, DOUT}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // impulse response
    for (int i = 0; i < int'(NT); i++) wcoef(i, 2 * (i + 1));
    run_impulse("impulse");

    // out-of-range coefficient writes leave the bank untouched
    for (int a = 11; a < 16; a++) wcoef(a, 127);
    run_impulse("coef_oor");

    // coefficient write on the same edge as a block applies to that block
    outq.delete();
    COEF_WE = 1'b1; COEF_ADDR = '0; COEF_DATA = 8'h10;
    blk(1'b1, 24'h000040);
    COEF_WE = 1'b0; VIN = 1'b0;
    repeat (3) step();
    chk("same_edge_h0", (outq.size() > 0) ? 32'(outq[0]) : 32'hFFFF_FFFF, 32'h030208);

    // gapped traffic versus back-to-back traffic
    async_reset();
    for (int i = 0; i < int'(NT); i++) begin
      gh[i] = int'($urandom_range(0, 255));
      wcoef(i, gh[i]);
    end
    for (int k = 0; k < 4; k++) d[k] = L*W'($urandom);
    outq.delete();
    blk(1'b1, d[0]);
    repeat (3) blk(1'b0, L*W'($urandom));
    blk(1'b1, d[1]);
    repeat (2) blk(1'b0, L*W'($urandom));
    blk(1'b1, d[2]);
    blk(1'b1, d[3]);
    VIN = 1'b0;
    repeat (3) step();
    gap_q = outq;
    async_reset();
    for (int i = 0; i < int'(NT); i++) wcoef(i, gh[i]);
    outq.delete();
    for (int k = 0; k < 4; k++) blk(1'b1, d[k]);
    VIN = 1'b0;
    repeat (3) step();
    chk("gap_count", outq.size(), gap_q.size());
    for (int k = 0; k < 4; k++)
      chk("gap_vs_b2b", (outq.size() > k) ? 32'(outq[k]) : 32'hFFFF_FFFF,
          (gap_q.size() > k) ? 32'(gap_q[k]) : 32'hEEEE_EEEE);

    // steady-state overflow table
    for (int t = 0; t < 5; t++) begin
      async_reset();
      for (int i = 0; i < int'(NT); i++) wcoef(i, int'(tbl[t].hv));
      repeat (8) blk(1'b1, {3{tbl[t].xv}});
      VIN = 1'b0;
      repeat (3) step();
      for (int j = 0; j < int'(L); j++)
        chk(tbl[t].name, 32'(DOUT[j*int'(W) +: W]), 32'(tbl[t].exp));
    end

    // reset with two blocks in flight
    async_reset();
    for (int i = 0; i < int'(NT); i++) wcoef(i, int'($urandom_range(0, 255)));
    repeat (4) blk(1'b1, L*W'($urandom));
    blk(1'b1, L*W'($urandom));
    blk(1'b1, L*W'($urandom));
    async_reset();
    outq.delete();
    VIN = 1'b0;
    repeat (4) step();
    chk("flush_no_vout", outq.size(), 32'd0);
    for (int i = 0; i < int'(NT); i++) wcoef(i, int'($urandom_range(0, 255)));
    blk(1'b1, L*W'($urandom));
    VIN = 1'b0;
    repeat (3) step();

    // randomized traffic with interleaved coefficient writes
    for (int c = 0; c < 300; c++) begin
      COEF_WE   = ($urandom_range(0, 7) == 0);
      COEF_ADDR = AW'($urandom_range(0, 15));
      COEF_DATA = W'($urandom);
      blk($urandom_range(0, 9) < 7, L*W'($urandom));
    end
    COEF_WE = 1'b0;
    VIN = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
